mc_main_controller: RTL and testbench
=====================================

# mc_main_controller

Next-generation main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode across fetch, decode, execute, memory and writeback states, and drives every datapath select and write enable as a Moore function of state. Compared with the current decoder, it adds:
- BNE, ANDI, ORI, SLTI and JAL.
- A memory-ready handshake.
- A trap on illegal opcodes.
- A retired-instruction counter.

It sits between the instruction register and the datapath/ALU decoder.

## Interface
Parameters:
- MEM_WAIT_EN, 1, 1 = FETCH/MEMRD/MEMWR hold until mem_ready; 0 = mem_ready ignored, treated as 1
- TRAP_EN, 1, 1 = illegal opcode parks in TRAP until reset; 0 = one-cycle TRAP then FETCH
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock; one clock, all state updates on rising edge
- reset  in  1  reset is synchronous and active-high
- op  in  6  opcode from instruction register
- mem_ready  in  1  memory access completes this cycle
- iord  out  1  memory address select (1 = ALUOut)
- irwrite  out  1  instruction register write
- memwrite  out  1  memory write
- memtoreg  out  2  00 ALUOut, 01 data reg, 10 PC (JAL link)
- regdst  out  2  00 rt, 01 rd, 10 r31
- regwrite  out  1  register file write
- alusrca  out  1  0 PC, 1 A
- alusrcb  out  3  000 B, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext imm
- aluop  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target
- pcwrite  out  1  unconditional PC write
- branch  out  1  PC write if zero
- branch_ne  out  1  PC write if not zero
- illegal  out  1  high while in TRAP
- instr_count  out  CNT_W  retired instructions
- state_o  out  5  current state (debug)

## Operation
- Single always_ff state register; outputs come from a combinational decode of state only.
- Every output has a defined value in every state; default 0.
- While reset is high, all write enables are forced 0: irwrite, memwrite, regwrite, pcwrite, branch, branch_ne.

State encodings and outputs. Outputs not listed are 0.
- FETCH 0: irwrite=1, pcwrite=1, alusrcb=001, aluop=000.
  - irwrite/pcwrite assert only when mem_ready (or MEM_WAIT_EN=0); stay here otherwise.
- DECODE 1: alusrcb=011, aluop=000.
  - Branches by op: 000000→RTYPEEX, 100011/101011→MEMADR, 000100→BEQEX, 000101→BNEEX, 001000→ADDIEX, 001100→ANDIEX, 001101→ORIEX, 001010→SLTIEX, 000010→JEX, 000011→JALEX, else→TRAP.
- MEMADR 2: alusrca=1, alusrcb=010; →MEMRD for LW, →MEMWR for SW.
- MEMRD 3: iord=1; →MEMWB when mem_ready, else hold.
- MEMWB 4: memtoreg=01, regwrite=1; →FETCH.
- MEMWR 5: iord=1, memwrite=1 (only when mem_ready); →FETCH when mem_ready, else hold.
- RTYPEEX 6: alusrca=1, aluop=010; →RTYPEWB.
- RTYPEWB 7: regdst=01, regwrite=1; →FETCH.
- BEQEX 8: alusrca=1, aluop=001, pcsrc=01, branch=1; →FETCH.
- BNEEX 9: as BEQEX but branch_ne=1 instead of branch; →FETCH.
- ADDIEX 10 (alusrcb=010, aluop=000), ANDIEX 11 (alusrcb=100, aluop=011), ORIEX 12 (alusrcb=100, aluop=100), SLTIEX 13 (alusrcb=010, aluop=101).
  - All four have alusrca=1 and go →IMMWB.
- IMMWB 14: regdst=00, memtoreg=00, regwrite=1; →FETCH.
- JEX 15: pcsrc=10, pcwrite=1; →FETCH.
- JALEX 16: pcsrc=10, pcwrite=1, regdst=10, memtoreg=10, regwrite=1; →FETCH.
  - The PC register already holds PC+4 from FETCH, so it is the link value.
- TRAP 17: illegal=1. Stays here if TRAP_EN=1; →FETCH next cycle if TRAP_EN=0.

Retired-instruction counter:
- instr_count increments by 1 on every transition into FETCH from any state other than FETCH or TRAP.
- Wraps modulo 2^CNT_W; no saturation.

## Timing
- Reset: state=FETCH, instr_count=0 at the first edge with reset high. Outputs then show the FETCH decode with write enables gated to 0.
- Reset mid-instruction aborts it with no count increment. Reset in TRAP returns to FETCH.
- Minimum cycles, memory ready every cycle:
  - LW 5; SW 4; R-type, ADDI, ANDI, ORI, SLTI 4; BEQ, BNE, J, JAL 3.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- instr_count reflects a retirement one cycle after the final state, i.e. in the following FETCH cycle.
- op is sampled in DECODE and MEMADR only. It must remain stable from irwrite until the next FETCH.

## Structure
- Package mc_ctrl_pkg holds:
  - state enum (5-bit, encodings above)
  - opcode localparams
  - aluop, alusrcb, pcsrc, memtoreg and regdst encodings
- Sub-module mc_retire_counter (CNT_W, clk, reset, inc, count) holds the counter. The FSM stays in mc_main_controller.

## Test plan
- LW, mem_ready=1: reset, op=100011 → states 0,1,2,3,4,0; regwrite=1 with memtoreg=01 in state 4 only; instr_count 0→1.
- SW with mem_ready low 2 cycles in MEMWR → memwrite high only in the mem_ready cycle; 6 cycles total; no regwrite.
- BNE then JAL → state 9 with branch_ne=1, pcsrc=01; then state 16 with regdst=10, memtoreg=10, pcwrite=1; count +2.
- ANDI/ORI → alusrcb=100 with aluop 011 and 100 respectively; SLTI → alusrcb=010, aluop=101; each 4 cycles.
- op=111111 with TRAP_EN=1 → state 17 held, illegal=1 indefinitely, count unchanged. With TRAP_EN=0 → illegal for 1 cycle, then FETCH.
- CNT_W=4: 16 R-type instructions → count wraps to 0. Reset asserted in RTYPEEX → FETCH next edge, count=0, no regwrite.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    FETCH   = 5'd0,
    DECODE  = 5'd1,
    MEMADR  = 5'd2,
    MEMRD   = 5'd3,
    MEMWB   = 5'd4,
    MEMWR   = 5'd5,
    RTYPEEX = 5'd6,
    RTYPEWB = 5'd7,
    BEQEX   = 5'd8,
    BNEEX   = 5'd9,
    ADDIEX  = 5'd10,
    ANDIEX  = 5'd11,
    ORIEX   = 5'd12,
    SLTIEX  = 5'd13,
    IMMWB   = 5'd14,
    JEX     = 5'd15,
    JALEX   = 5'd16,
    TRAP    = 5'd17
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [2:0] SRCB_B      = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_SIMM   = 3'b010;
  localparam logic [2:0] SRCB_SIMM_2 = 3'b011;
  localparam logic [2:0] SRCB_ZIMM   = 3'b100;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_DATA   = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  // Execute state entered from DECODE for a given opcode.
  function automatic state_t decode_op(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE:     return RTYPEEX;
      OP_LW, OP_SW: return MEMADR;
      OP_BEQ:       return BEQEX;
      OP_BNE:       return BNEEX;
      OP_ADDI:      return ADDIEX;
      OP_ANDI:      return ANDIEX;
      OP_ORI:       return ORIEX;
      OP_SLTI:      return SLTIEX;
      OP_J:         return JEX;
      OP_JAL:       return JALEX;
      default:      return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mc_main_controller_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
module mc_retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) count_reg <= '0;
    else if (inc) count_reg <= count_reg + CNT_W'(1);
  end

  assign count = count_reg;

endmodule

// File: rtl/mc_main_controller.sv
// Multicycle MIPS main control FSM: Moore outputs decoded from state only,
// with memory-ready stalls, illegal-opcode trap and a retirement counter.
module mc_main_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_EN = 1,
  parameter int TRAP_EN     = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic [1:0]       memtoreg,
  output logic [1:0]       regdst,
  output logic             regwrite,
  output logic             alusrca,
  output logic [2:0]       alusrcb,
  output logic [2:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             pcwrite,
  output logic             branch,
  output logic             branch_ne,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [4:0]       state_o
);

  state_t state_reg, state_next;
  logic   mem_ok;
  logic   retire;

  assign mem_ok = (MEM_WAIT_EN == 0) || mem_ready;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (mem_ok) state_next = DECODE;
      DECODE:  state_next = decode_op(op);
      MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ok) state_next = MEMWB;
      MEMWR:   if (mem_ok) state_next = FETCH;
      RTYPEEX: state_next = RTYPEWB;
      ADDIEX, ANDIEX, ORIEX, SLTIEX: state_next = IMMWB;
      TRAP:    state_next = (TRAP_EN != 0) ? TRAP : FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    iord      = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = M2R_ALUOUT;
    regdst    = RD_RT;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = SRCB_B;
    aluop     = ALU_ADD;
    pcsrc     = PC_ALU;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    illegal   = 1'b0;
    case (state_reg)
      FETCH: begin
        irwrite = mem_ok;
        pcwrite = mem_ok;
        alusrcb = SRCB_FOUR;
      end
      DECODE:  alusrcb = SRCB_SIMM_2;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_SIMM;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        memtoreg = M2R_DATA;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = mem_ok;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALU_FUNCT;
      end
      RTYPEWB: begin
        regdst   = RD_RD;
        regwrite = 1'b1;
      end
      BEQEX, BNEEX: begin
        alusrca   = 1'b1;
        aluop     = ALU_SUB;
        pcsrc     = PC_ALUOUT;
        branch    = (state_reg == BEQEX);
        branch_ne = (state_reg == BNEEX);
      end
      ADDIEX: begin alusrca = 1'b1; alusrcb = SRCB_SIMM; aluop = ALU_ADD; end
      ANDIEX: begin alusrca = 1'b1; alusrcb = SRCB_ZIMM; aluop = ALU_AND; end
      ORIEX:  begin alusrca = 1'b1; alusrcb = SRCB_ZIMM; aluop = ALU_OR;  end
      SLTIEX: begin alusrca = 1'b1; alusrcb = SRCB_SIMM; aluop = ALU_SLT; end
      IMMWB:   regwrite = 1'b1;
      JEX: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      // PC already holds PC+4 from FETCH, so it doubles as the link value.
      JALEX: begin
        pcsrc    = PC_JUMP;
        pcwrite  = 1'b1;
        regdst   = RD_R31;
        memtoreg = M2R_PC;
        regwrite = 1'b1;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
    if (reset) begin
      irwrite   = 1'b0;
      memwrite  = 1'b0;
      regwrite  = 1'b0;
      pcwrite   = 1'b0;
      branch    = 1'b0;
      branch_ne = 1'b0;
    end
  end

  // A trap or a stalled fetch re-entering FETCH is not a retirement.
  assign retire = (state_next == FETCH) && (state_reg != FETCH) && (state_reg != TRAP);

  mc_retire_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .count (instr_count)
  );

  assign state_o = state_reg;

endmodule

// File: tb/tb_mc_main_controller.sv
// Scoreboard bench: driver queues per-cycle expectations, negedge monitor compares.
module tb_mc_main_controller;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5;
  localparam int S_RX = 6, S_RWB = 7, S_BEQ = 8, S_BNE = 9, S_ADDI = 10, S_ANDI = 11;
  localparam int S_ORI = 12, S_SLTI = 13, S_IWB = 14, S_J = 15, S_JAL = 16, S_TRAP = 17;
  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011;
  localparam logic [5:0] O_BEQ = 6'b000100, O_BNE = 6'b000101, O_ADDI = 6'b001000;
  localparam logic [5:0] O_ANDI = 6'b001100, O_ORI = 6'b001101, O_SLTI = 6'b001010;
  localparam logic [5:0] O_J = 6'b000010, O_JAL = 6'b000011, O_ILL = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: defaults. Instance b: no memory wait, one-cycle trap, 4-bit counter.
  logic reset_a, mem_ready_a, reset_b, mem_ready_b;
  logic [5:0] op_a, op_b;
  logic iord_a, irwrite_a, memwrite_a, regwrite_a, alusrca_a, pcwrite_a, branch_a, branch_ne_a, illegal_a;
  logic iord_b, irwrite_b, memwrite_b, regwrite_b, alusrca_b, pcwrite_b, branch_b, branch_ne_b, illegal_b;
  logic [1:0] memtoreg_a, regdst_a, pcsrc_a, memtoreg_b, regdst_b, pcsrc_b;
  logic [2:0] alusrcb_a, aluop_a, alusrcb_b, aluop_b;
  logic [31:0] cnt_a;
  logic [3:0] cnt_b;
  logic [4:0] st_a, st_b;
  logic [20:0] ctl_a, ctl_b;

  mc_main_controller dut_a (
    .clk(clk), .reset(reset_a), .op(op_a), .mem_ready(mem_ready_a),
    .iord(iord_a), .irwrite(irwrite_a), .memwrite(memwrite_a), .memtoreg(memtoreg_a),
    .regdst(regdst_a), .regwrite(regwrite_a), .alusrca(alusrca_a), .alusrcb(alusrcb_a),
    .aluop(aluop_a), .pcsrc(pcsrc_a), .pcwrite(pcwrite_a), .branch(branch_a),
    .branch_ne(branch_ne_a), .illegal(illegal_a), .instr_count(cnt_a), .state_o(st_a)
  );

  mc_main_controller #(.MEM_WAIT_EN(0), .TRAP_EN(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset_b), .op(op_b), .mem_ready(mem_ready_b),
    .iord(iord_b), .irwrite(irwrite_b), .memwrite(memwrite_b), .memtoreg(memtoreg_b),
    .regdst(regdst_b), .regwrite(regwrite_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b),
    .aluop(aluop_b), .pcsrc(pcsrc_b), .pcwrite(pcwrite_b), .branch(branch_b),
    .branch_ne(branch_ne_b), .illegal(illegal_b), .instr_count(cnt_b), .state_o(st_b)
  );

  assign ctl_a = {iord_a, irwrite_a, memwrite_a, memtoreg_a, regdst_a, regwrite_a, alusrca_a,
                  alusrcb_a, aluop_a, pcsrc_a, pcwrite_a, branch_a, branch_ne_a, illegal_a};
  assign ctl_b = {iord_b, irwrite_b, memwrite_b, memtoreg_b, regdst_b, regwrite_b, alusrca_b,
                  alusrcb_b, aluop_b, pcsrc_b, pcwrite_b, branch_b, branch_ne_b, illegal_b};

  typedef struct {
    bit          sel;
    string       tag;
    logic [4:0]  st;
    logic [20:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cnt_exp_a = 0;
  int cnt_exp_b = 0;

  // Control word expected in state st, written straight from the state table.
  function automatic logic [20:0] exp_ctl(input int st, input bit rst, input bit mr, input bit wait_en);
    logic iord = 0, irw = 0, mw = 0, rw = 0, asa = 0, pcw = 0, br = 0, bne = 0, ill = 0;
    logic [1:0] m2r = 0, rd = 0, pcs = 0;
    logic [2:0] srcb = 0, aop = 0;
    bit ok;
    ok = wait_en ? mr : 1'b1;
    case (st)
      S_F:    begin irw = ok; pcw = ok; srcb = 3'b001; end
      S_D:    srcb = 3'b011;
      S_MA:   begin asa = 1; srcb = 3'b010; end
      S_MR:   iord = 1;
      S_MWB:  begin m2r = 2'b01; rw = 1; end
      S_MW:   begin iord = 1; mw = ok; end
      S_RX:   begin asa = 1; aop = 3'b010; end
      S_RWB:  begin rd = 2'b01; rw = 1; end
      S_BEQ:  begin asa = 1; aop = 3'b001; pcs = 2'b01; br = 1; end
      S_BNE:  begin asa = 1; aop = 3'b001; pcs = 2'b01; bne = 1; end
      S_ADDI: begin asa = 1; srcb = 3'b010; aop = 3'b000; end
      S_ANDI: begin asa = 1; srcb = 3'b100; aop = 3'b011; end
      S_ORI:  begin asa = 1; srcb = 3'b100; aop = 3'b100; end
      S_SLTI: begin asa = 1; srcb = 3'b010; aop = 3'b101; end
      S_IWB:  rw = 1;
      S_J:    begin pcs = 2'b10; pcw = 1; end
      S_JAL:  begin pcs = 2'b10; pcw = 1; rd = 2'b10; m2r = 2'b10; rw = 1; end
      S_TRAP: ill = 1;
      default: ;
    endcase
    if (rst) begin irw = 0; mw = 0; rw = 0; pcw = 0; br = 0; bne = 0; end
    return {iord, irw, mw, m2r, rd, rw, asa, srcb, aop, pcs, pcw, br, bne, ill};
  endfunction

  // One clock cycle of stimulus plus the expectation for that cycle.
  task automatic cyc(input bit sel, input string tag, input bit rst, input logic [5:0] o,
                     input bit mr, input int st);
    exp_t e;
    if (sel) begin reset_b = rst; op_b = o; mem_ready_b = mr; end
    else     begin reset_a = rst; op_a = o; mem_ready_a = mr; end
    e.sel = sel;
    e.tag = tag;
    e.st  = 5'(st);
    e.ctl = exp_ctl(st, rst, mr, !sel);
    e.cnt = sel ? 32'(cnt_exp_b % 16) : 32'(cnt_exp_a);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // FETCH, DECODE, then one or two execute states (s3 < 0 means none).
  task automatic instr(input bit sel, input string tag, input logic [5:0] o,
                       input int s2, input int s3, input bit retires);
    cyc(sel, tag, 0, o, 1, S_F);
    cyc(sel, tag, 0, o, 1, S_D);
    cyc(sel, tag, 0, o, 1, s2);
    if (s3 >= 0) cyc(sel, tag, 0, o, 1, s3);
    if (retires) begin
      if (sel) cnt_exp_b++;
      else     cnt_exp_a++;
    end
    $display("instr %s issued on dut_%s", tag, sel ? "b" : "a");
  endtask

  initial begin : monitor
    exp_t e;
    logic [4:0]  ast;
    logic [20:0] actl;
    logic [31:0] acnt;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e    = q.pop_front();
        ast  = e.sel ? st_b : st_a;
        actl = e.sel ? ctl_b : ctl_a;
        acnt = e.sel ? {28'd0, cnt_b} : cnt_a;
        n_vec++;
        if (ast !== e.st || actl !== e.ctl || acnt !== e.cnt) begin
          n_bad++;
          $display("FAIL %s: got state %0d ctl %h count %0d, want state %0d ctl %h count %0d",
                   e.tag, ast, actl, acnt, e.st, e.ctl, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    reset_a = 1; op_a = O_R; mem_ready_a = 1;
    reset_b = 1; op_b = O_R; mem_ready_b = 1;
    @(posedge clk);
    #1;
    cyc(0, "RESET_A", 1, O_R, 1, S_F);

    cyc(0, "LW", 0, O_LW, 1, S_F);
    cyc(0, "LW", 0, O_LW, 1, S_D);
    cyc(0, "LW", 0, O_LW, 1, S_MA);
    cyc(0, "LW", 0, O_LW, 1, S_MR);
    cyc(0, "LW", 0, O_LW, 1, S_MWB);
    cnt_exp_a++;

    cyc(0, "SW", 0, O_SW, 1, S_F);
    cyc(0, "SW", 0, O_SW, 1, S_D);
    cyc(0, "SW", 0, O_SW, 1, S_MA);
    cyc(0, "SW", 0, O_SW, 0, S_MW);
    cyc(0, "SW", 0, O_SW, 0, S_MW);
    cyc(0, "SW", 0, O_SW, 1, S_MW);
    cnt_exp_a++;

    instr(0, "BNE",  O_BNE,  S_BNE,  -1,    1);
    instr(0, "JAL",  O_JAL,  S_JAL,  -1,    1);
    instr(0, "ANDI", O_ANDI, S_ANDI, S_IWB, 1);
    instr(0, "ORI",  O_ORI,  S_ORI,  S_IWB, 1);
    instr(0, "SLTI", O_SLTI, S_SLTI, S_IWB, 1);
    instr(0, "ADDI", O_ADDI, S_ADDI, S_IWB, 1);
    instr(0, "BEQ",  O_BEQ,  S_BEQ,  -1,    1);
    instr(0, "J",    O_J,    S_J,    -1,    1);
    instr(0, "RTYPE", O_R,   S_RX,   S_RWB, 1);

    cyc(0, "LW_STALL", 0, O_LW, 0, S_F);
    cyc(0, "LW_STALL", 0, O_LW, 1, S_F);
    cyc(0, "LW_STALL", 0, O_LW, 1, S_D);
    cyc(0, "LW_STALL", 0, O_LW, 1, S_MA);
    cyc(0, "LW_STALL", 0, O_LW, 0, S_MR);
    cyc(0, "LW_STALL", 0, O_LW, 1, S_MR);
    cyc(0, "LW_STALL", 0, O_LW, 1, S_MWB);
    cnt_exp_a++;

    cyc(0, "TRAP", 0, O_ILL, 1, S_F);
    cyc(0, "TRAP", 0, O_ILL, 1, S_D);
    for (int i = 0; i < 5; i++) cyc(0, "TRAP_HOLD", 0, O_ILL, 1, S_TRAP);
    cyc(0, "TRAP_RST", 1, O_ILL, 1, S_TRAP);
    cnt_exp_a = 0;
    cyc(0, "TRAP_RST", 0, O_R, 1, S_F);
    $display("instr TRAP parked and cleared on dut_a");

    cyc(1, "RESET_B", 1, O_R, 1, S_F);
    cyc(1, "NOWAIT", 0, O_R, 0, S_F);
    cyc(1, "NOWAIT", 0, O_R, 0, S_D);
    cyc(1, "NOWAIT", 0, O_R, 0, S_RX);
    cyc(1, "NOWAIT", 0, O_R, 0, S_RWB);
    cnt_exp_b++;
    instr(1, "TRAP1", O_ILL, S_TRAP, -1, 0);
    for (int i = 0; i < 15; i++) instr(1, "RWRAP", O_R, S_RX, S_RWB, 1);
    instr(1, "RPOST", O_R, S_RX, S_RWB, 1);

    cyc(1, "RST_EX", 0, O_R, 1, S_F);
    cyc(1, "RST_EX", 0, O_R, 1, S_D);
    cyc(1, "RST_EX", 1, O_R, 1, S_RX);
    cnt_exp_b = 0;
    cyc(1, "RST_EX", 0, O_R, 1, S_F);
    cyc(1, "RST_EX", 0, O_R, 1, S_D);
    $display("instr RTYPE aborted by reset on dut_b");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
